vc_flit_buffer_cr: RTL and testbench
====================================

Name: vc_flit_buffer_cr

Overview:
Parametrised successor of the router input-port flit buffer. Holds V virtual channels, each a circular FIFO of B flits, in one shared B*V-entry memory. Adds per-VC occupancy and full/almost-full flags, per-VC credit return toward the upstream router, and a real single-cycle speculative (SSA) read path. Also adds sticky overflow/underflow error flags. Sits at each router input port, between the link receiver and the VC allocator / switch allocator.

Parameters:
V, 4, number of virtual channels (>=1).
B, 4, flit slots per VC (power of two, >=2).
Fpay, 32, payload width.
SSA_EN, "NO", "YES" enables the ssa_rd path; "NO" ignores ssa_rd.
AF_TH, 1, almost-full asserted when free slots <= AF_TH.
Fw (local), 2+V+Fpay, flit width: bit Fw-1 is header, bit Fw-2 is tail, then V-bit VC field, then payload.
Dw (local), clog2(B+1), occupancy width.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
din  in  Fw  write flit.
vc_num_wr  in  V  one-hot VC select for write.
wr_en  in  1  write strobe.
vc_num_rd  in  V  one-hot VC select for normal read.
rd_en  in  1  normal read strobe.
ssa_rd  in  V  one-hot speculative read (at most one bit set).
dout  out  Fw  read data, registered.
dout_valid  out  1  dout holds a flit popped last cycle.
vc_not_empty  out  V  per-VC occupancy != 0.
vc_full  out  V  per-VC occupancy == B.
vc_almost_full  out  V  per-VC (B - occupancy) <= AF_TH.
vc_occupancy  out  V*Dw  packed per-VC counts; VC i is at [i*Dw +: Dw].
credit_out  out  V  one-cycle pulse per popped flit, one-hot.
err_overflow  out  1  sticky: a write targeted a full VC.
err_underflow  out  1  sticky: a read targeted an empty VC.

Behaviour:
- Reset (synchronous, active-high, at a clk edge). All write pointers, read pointers and counters go to 0. dout=0, dout_valid=0, credit_out=0, error flags=0. Memory contents are not cleared.
- Reset mid-operation discards all stored flits. No credits are returned for discarded flits.
- Addressing: VC i occupies memory rows [i*B, i*B+B-1]. Pointers are log2(B) bits and wrap modulo B. Occupancy is tracked by a separate Dw-bit counter, not by pointer difference.
- Write: when wr_en=1 and the selected VC is not full, store din at the write pointer and increment the pointer. If the VC is full, drop the flit, set err_overflow, and leave state unchanged.
- Read select: the pop is taken from vc_num_rd when rd_en=1. Otherwise, when SSA_EN="YES", it is taken from ssa_rd when ssa_rd!=0. rd_en has priority and ssa_rd is ignored that cycle. At most one pop per cycle.
- Pop of a non-empty VC:
  - dout loads the memory word at the next clk edge, and dout_valid=1 for that one cycle. Latency from pop to data is 1 cycle.
  - The read pointer increments.
  - credit_out[vc] pulses for one cycle, aligned with dout_valid.
- Pop of an empty VC: no state change, dout_valid=0, no credit, err_underflow set.
- When no pop occurs, dout holds its last value and dout_valid=0.
- Simultaneous write and pop on the same VC:
  - Occupancy is unchanged.
  - Allowed when full: pop-before-write, so the write is accepted with no overflow.
  - When empty: the pop is an underflow and the write is accepted. There is no bypass; the written flit is readable from the next cycle.
- Simultaneous write and pop on different VCs: fully independent.
- Flags (vc_not_empty, vc_full, vc_almost_full, vc_occupancy) are combinational from the counters and reflect state after the last edge.
- One-hot violation (more than one bit set in vc_num_wr or a selected read vector): the operation is ignored and the matching error flag is set.
- Error flags clear only on reset.

Test Plan:
- Reset, then write flits 0xA0..0xA3 to VC1 (V=4, B=4) → vc_full=4'b0010, vc_occupancy VC1=4, others 0; a 5th write sets err_overflow=1 and occupancy stays 4.
- Pop VC1 four times → dout=0xA0,0xA1,0xA2,0xA3 in order, each one cycle after rd_en with dout_valid=1 and credit_out=4'b0010; afterwards vc_not_empty[1]=0.
- Write/pop 10 flits through VC2, keeping occupancy 1–3 → pointer wrap-around preserves order; occupancy is never >B; no error flags.
- VC0 full, simultaneous wr_en and rd_en on VC0 → occupancy stays 4, err_overflow stays 0, popped flit is the oldest.
- SSA_EN="YES": ssa_rd=4'b0100 with rd_en=0 → VC2 pops with credit_out=4'b0100. Same cycle, rd_en=1 on VC3 → VC3 pops and VC2 does not. SSA_EN="NO": ssa_rd alone → no pop, no credit.
- Reset asserted with VCs partly filled → next cycle all counters 0, vc_not_empty=0, no credit pulses, error flags cleared; a pop of VC0 then sets err_underflow.

Source files
------------

// File: rtl/vc_flit_buffer_cr.sv
// vc_flit_buffer_cr: V circular flit FIFOs sharing one B*V-entry memory,
// with per-VC credits, occupancy flags and an optional speculative read port.
module vc_flit_buffer_cr #(
  parameter int    V      = 4,
  parameter int    B      = 4,
  parameter int    Fpay   = 32,
  parameter string SSA_EN = "NO",
  parameter int    AF_TH  = 1,
  localparam int   Fw     = 2 + V + Fpay,
  localparam int   Dw     = $clog2(B + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Fw-1:0]   din,
  input  logic [V-1:0]    vc_num_wr,
  input  logic            wr_en,
  input  logic [V-1:0]    vc_num_rd,
  input  logic            rd_en,
  input  logic [V-1:0]    ssa_rd,
  output logic [Fw-1:0]   dout,
  output logic            dout_valid,
  output logic [V-1:0]    vc_not_empty,
  output logic [V-1:0]    vc_full,
  output logic [V-1:0]    vc_almost_full,
  output logic [V*Dw-1:0] vc_occupancy,
  output logic [V-1:0]    credit_out,
  output logic            err_overflow,
  output logic            err_underflow
);
  localparam int Pw = $clog2(B);
  localparam int Vw = (V > 1) ? $clog2(V) : 1;
  localparam int Aw = Vw + Pw;
  localparam logic [Dw-1:0] FULL = Dw'(B);
  localparam bit SSA_ON = (SSA_EN == "YES");

  logic [Fw-1:0] mem_q [V*B];
  logic [Pw-1:0] wr_ptr_q [V];
  logic [Pw-1:0] rd_ptr_q [V];
  logic [Dw-1:0] cnt_q [V];
  logic [Fw-1:0] dout_q;
  logic          dout_valid_q;
  logic [V-1:0]  credit_q;
  logic          ovf_q;
  logic          udf_q;

  logic [Vw-1:0] wr_idx;
  logic [Vw-1:0] rd_idx;
  logic [V-1:0]  rd_vec;
  logic [V-1:0]  inc;
  logic [V-1:0]  dec;
  logic          rd_req;
  logic          push;
  logic          pop;
  logic          wr_err;
  logic          rd_err;
  logic [Aw-1:0] wr_addr;
  logic [Aw-1:0] rd_addr;

  always_comb begin
    wr_idx = '0;
    rd_idx = '0;
    rd_req = rd_en | (SSA_ON & (|ssa_rd));
    rd_vec = rd_en ? vc_num_rd : (SSA_ON ? ssa_rd : '0);
    for (int i = 0; i < V; i++) begin
      if (vc_num_wr[i]) wr_idx = Vw'(i);
      if (rd_vec[i]) rd_idx = Vw'(i);
    end
    pop = rd_req && $onehot(rd_vec) && (cnt_q[rd_idx] != '0);
    rd_err = rd_req && !pop;
    // a pop on the same VC frees a slot first, so a full VC still accepts
    push = wr_en && $onehot(vc_num_wr) &&
           ((cnt_q[wr_idx] != FULL) || (pop && (rd_idx == wr_idx)));
    wr_err = wr_en && !push;
    wr_addr = {wr_idx, wr_ptr_q[wr_idx]};
    rd_addr = {rd_idx, rd_ptr_q[rd_idx]};
    inc = vc_num_wr & {V{push}};
    dec = rd_vec & {V{pop}};
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < V; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      credit_q     <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      if (push) wr_ptr_q[wr_idx] <= wr_ptr_q[wr_idx] + Pw'(1);
      if (pop) begin
        rd_ptr_q[rd_idx] <= rd_ptr_q[rd_idx] + Pw'(1);
        dout_q           <= mem_q[rd_addr];
      end
      dout_valid_q <= pop;
      credit_q     <= dec;
      for (int i = 0; i < V; i++) begin
        unique case ({inc[i], dec[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + Dw'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - Dw'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      ovf_q <= ovf_q | wr_err;
      udf_q <= udf_q | rd_err;
    end
  end

  always_comb begin
    vc_not_empty   = '0;
    vc_full        = '0;
    vc_almost_full = '0;
    vc_occupancy   = '0;
    for (int i = 0; i < V; i++) begin
      vc_not_empty[i]          = cnt_q[i] != '0;
      vc_full[i]               = cnt_q[i] == FULL;
      vc_almost_full[i]        = (B - int'(cnt_q[i])) <= AF_TH;
      vc_occupancy[i*Dw +: Dw] = cnt_q[i];
    end
  end

  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign credit_out    = credit_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;

endmodule

// File: tb/tb_vc_flit_buffer_cr.sv
// Bench for vc_flit_buffer_cr: directed scenarios plus random traffic
// against a queue-based model, on an SSA-enabled and an SSA-disabled copy.
module tb_vc_flit_buffer_cr;
  localparam int V = 4;
  localparam int B = 4;
  localparam int Fpay = 32;
  localparam int Fw = 2 + V + Fpay;
  localparam int Dw = $clog2(B + 1);
  localparam int GW = Fw + V*Dw + 4*V + 3;

  logic clk = 1'b0;
  logic reset;
  logic [Fw-1:0] din;
  logic [V-1:0] vc_num_wr, vc_num_rd, ssa_rd;
  logic wr_en, rd_en;

  logic [Fw-1:0] dout_y, dout_n;
  logic dv_y, dv_n;
  logic [V-1:0] ne_y, ne_n, full_y, full_n, af_y, af_n, cr_y, cr_n;
  logic [V*Dw-1:0] occ_y, occ_n;
  logic ovf_y, ovf_n, udf_y, udf_n;

  always #5 clk = ~clk;

  vc_flit_buffer_cr #(.V(V), .B(B), .Fpay(Fpay), .SSA_EN("YES"), .AF_TH(1)) dut_y (
    .clk(clk), .reset(reset), .din(din), .vc_num_wr(vc_num_wr),
    .wr_en(wr_en), .vc_num_rd(vc_num_rd), .rd_en(rd_en), .ssa_rd(ssa_rd),
    .dout(dout_y), .dout_valid(dv_y), .vc_not_empty(ne_y),
    .vc_full(full_y), .vc_almost_full(af_y), .vc_occupancy(occ_y),
    .credit_out(cr_y), .err_overflow(ovf_y), .err_underflow(udf_y));

  vc_flit_buffer_cr #(.V(V), .B(B), .Fpay(Fpay), .SSA_EN("NO"), .AF_TH(1)) dut_n (
    .clk(clk), .reset(reset), .din(din), .vc_num_wr(vc_num_wr),
    .wr_en(wr_en), .vc_num_rd(vc_num_rd), .rd_en(rd_en), .ssa_rd(ssa_rd),
    .dout(dout_n), .dout_valid(dv_n), .vc_not_empty(ne_n),
    .vc_full(full_n), .vc_almost_full(af_n), .vc_occupancy(occ_n),
    .credit_out(cr_n), .err_overflow(ovf_n), .err_underflow(udf_n));

  // model index 0 = SSA enabled copy, 1 = SSA disabled copy
  logic [Fw-1:0] mq [2][V][$];
  logic m_ovf [2];
  logic m_udf [2];
  logic m_val [2];
  logic [Fw-1:0] m_dout [2];
  logic [V-1:0] m_cred [2];
  int tests = 0;
  int fails = 0;

  task automatic model_step();
    logic [V-1:0] pv;
    bit req;
    int pi, wi;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int v = 0; v < V; v++) mq[m][v].delete();
        m_ovf[m] = 0; m_udf[m] = 0; m_val[m] = 0;
        m_dout[m] = '0; m_cred[m] = '0;
      end else begin
        req = rd_en || (m == 0 && ssa_rd != '0);
        pv = rd_en ? vc_num_rd : (m == 0 ? ssa_rd : '0);
        m_val[m] = 0; m_cred[m] = '0;
        pi = 0; wi = 0;
        for (int i = 0; i < V; i++) begin
          if (pv[i]) pi = i;
          if (vc_num_wr[i]) wi = i;
        end
        if (req) begin
          if ($countones(pv) == 1 && mq[m][pi].size() > 0) begin
            m_dout[m] = mq[m][pi].pop_front();
            m_val[m] = 1; m_cred[m] = pv;
          end else m_udf[m] = 1;
        end
        if (wr_en) begin
          if ($countones(vc_num_wr) == 1 && mq[m][wi].size() < B)
            mq[m][wi].push_back(din);
          else m_ovf[m] = 1;
        end
      end
    end
  endtask

  function automatic logic [V*Dw-1:0] e_occ(int m);
    logic [V*Dw-1:0] r = '0;
    for (int v = 0; v < V; v++) r[v*Dw +: Dw] = Dw'(mq[m][v].size());
    return r;
  endfunction

  function automatic logic [V-1:0] e_ne(int m);
    logic [V-1:0] r = '0;
    for (int v = 0; v < V; v++) r[v] = mq[m][v].size() != 0;
    return r;
  endfunction

  function automatic logic [V-1:0] e_full(int m);
    logic [V-1:0] r = '0;
    for (int v = 0; v < V; v++) r[v] = mq[m][v].size() == B;
    return r;
  endfunction

  function automatic logic [V-1:0] e_af(int m);
    logic [V-1:0] r = '0;
    for (int v = 0; v < V; v++) r[v] = (B - mq[m][v].size()) <= 1;
    return r;
  endfunction

  task automatic idle();
    reset = 0; wr_en = 0; rd_en = 0; ssa_rd = '0;
    vc_num_wr = '0; vc_num_rd = '0; din = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (occ_y !== '0 || occ_n !== '0) begin
      fails++; $display("FAIL reset_occ got %h/%h exp 0", occ_y, occ_n);
    end
    tests++;
    if ({dv_y, cr_y, ne_y, ovf_y, udf_y} !== '0) begin
      fails++; $display("FAIL reset_flags got %b %b %b %b %b exp 0",
                        dv_y, cr_y, ne_y, ovf_y, udf_y);
    end
    tests++;
    if (dout_y !== '0) begin
      fails++; $display("FAIL reset_dout got %h exp 0", dout_y);
    end
  endtask

  task automatic test_fill_overflow();
    idle();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; vc_num_wr = 4'b0010; din = Fw'(32'hA0 + i);
      tick();
    end
    idle();
    tests++;
    if (full_y !== 4'b0010) begin
      fails++; $display("FAIL fill_full got %b exp 0010", full_y);
    end
    tests++;
    if (occ_y !== 12'h020) begin
      fails++; $display("FAIL fill_occ got %h exp 020", occ_y);
    end
    wr_en = 1; vc_num_wr = 4'b0010; din = Fw'(32'hA4);
    tick(); idle();
    tests++;
    if (ovf_y !== 1'b1 || occ_y !== 12'h020) begin
      fails++; $display("FAIL overflow got ovf=%b occ=%h exp 1 020", ovf_y, occ_y);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      idle(); rd_en = 1; vc_num_rd = 4'b0010;
      tick();
      tests++;
      if (dv_y !== 1'b1 || dout_y !== Fw'(32'hA0 + i) || cr_y !== 4'b0010) begin
        fails++; $display("FAIL drain%0d got v=%b d=%h c=%b exp 1 %h 0010",
                          i, dv_y, dout_y, cr_y, 32'hA0 + i);
      end
    end
    idle();
    tests++;
    if (ne_y[1] !== 1'b0) begin
      fails++; $display("FAIL drain_empty got %b exp 0", ne_y[1]);
    end
    tick();
    tests++;
    if (dv_y !== 1'b0 || cr_y !== '0 || dout_y !== Fw'(32'hA3)) begin
      fails++; $display("FAIL drain_hold got v=%b c=%b d=%h exp 0 0 a3",
                        dv_y, cr_y, dout_y);
    end
  endtask

  task automatic test_wrap();
    logic [Fw-1:0] sent [$];
    logic [Fw-1:0] ex;
    int ns, nr, cyc, sz;
    bit popped;
    do_reset();
    ns = 0; nr = 0; cyc = 0;
    while (nr < 10 && cyc < 200) begin
      idle();
      sz = sent.size();
      vc_num_wr = 4'b0100; vc_num_rd = 4'b0100;
      wr_en = (ns < 10) && (sz < 3) && (sz == 0 || $urandom_range(0, 2) != 0);
      rd_en = (sz > 1) || (sz == 1 && ($urandom_range(0, 1) == 1 || ns == 10));
      din = Fw'($urandom);
      popped = rd_en;
      ex = (sz > 0) ? sent[0] : '0;
      if (popped) void'(sent.pop_front());
      if (wr_en) begin sent.push_back(din); ns++; end
      tick(); cyc++;
      tests++;
      if (dv_y !== popped || (popped && dout_y !== ex)) begin
        fails++; $display("FAIL wrap_data got v=%b d=%h exp %b %h",
                          dv_y, dout_y, popped, ex);
      end
      if (popped) nr++;
      tests++;
      if (occ_y[2*Dw +: Dw] !== Dw'(sent.size()) || occ_y[2*Dw +: Dw] > B) begin
        fails++; $display("FAIL wrap_occ got %0d exp %0d",
                          occ_y[2*Dw +: Dw], sent.size());
      end
    end
    idle();
    tests++;
    if (nr != 10 || ovf_y !== 1'b0 || udf_y !== 1'b0) begin
      fails++; $display("FAIL wrap_end got n=%0d ovf=%b udf=%b exp 10 0 0",
                        nr, ovf_y, udf_y);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; vc_num_wr = 4'b0001; din = Fw'(32'hB0 + i);
      tick();
    end
    wr_en = 1; vc_num_wr = 4'b0001; din = Fw'(32'hB4);
    rd_en = 1; vc_num_rd = 4'b0001;
    tick(); idle();
    tests++;
    if (occ_y[Dw-1:0] !== 3'd4 || ovf_y !== 1'b0 || dout_y !== Fw'(32'hB0)
        || dv_y !== 1'b1) begin
      fails++; $display("FAIL full_simul got occ=%0d ovf=%b d=%h v=%b exp 4 0 b0 1",
                        occ_y[Dw-1:0], ovf_y, dout_y, dv_y);
    end
    for (int i = 1; i < 5; i++) begin
      idle(); rd_en = 1; vc_num_rd = 4'b0001;
      tick();
      tests++;
      if (dout_y !== Fw'(32'hB0 + i)) begin
        fails++; $display("FAIL full_order%0d got %h exp %h", i, dout_y, 32'hB0 + i);
      end
    end
    idle();
  endtask

  task automatic test_ssa();
    do_reset();
    wr_en = 1; vc_num_wr = 4'b0100; din = Fw'(32'hC2); tick();
    vc_num_wr = 4'b1000; din = Fw'(32'hC3); tick();
    idle(); ssa_rd = 4'b0100;
    tick();
    tests++;
    if (dv_y !== 1'b1 || cr_y !== 4'b0100 || dout_y !== Fw'(32'hC2)) begin
      fails++; $display("FAIL ssa_pop got v=%b c=%b d=%h exp 1 0100 c2",
                        dv_y, cr_y, dout_y);
    end
    tests++;
    if (dv_n !== 1'b0 || cr_n !== '0 || udf_n !== 1'b0 || occ_n[2*Dw +: Dw] !== 3'd1) begin
      fails++; $display("FAIL ssa_off got v=%b c=%b u=%b occ=%0d exp 0 0 0 1",
                        dv_n, cr_n, udf_n, occ_n[2*Dw +: Dw]);
    end
    idle(); wr_en = 1; vc_num_wr = 4'b0100; din = Fw'(32'hD2); tick();
    idle(); ssa_rd = 4'b0100; rd_en = 1; vc_num_rd = 4'b1000;
    tick(); idle();
    tests++;
    if (cr_y !== 4'b1000 || dout_y !== Fw'(32'hC3) || occ_y[2*Dw +: Dw] !== 3'd1) begin
      fails++; $display("FAIL ssa_prio got c=%b d=%h occ2=%0d exp 1000 c3 1",
                        cr_y, dout_y, occ_y[2*Dw +: Dw]);
    end
    tests++;
    if (cr_n !== 4'b1000 || dout_n !== Fw'(32'hC3)) begin
      fails++; $display("FAIL ssa_off_rd got c=%b d=%h exp 1000 c3", cr_n, dout_n);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_en = 1; vc_num_wr = 4'b0001; din = Fw'(32'hE0); tick();
    vc_num_wr = 4'b0010; din = Fw'(32'hE1); tick();
    vc_num_wr = 4'b0011; tick();
    idle(); rd_en = 1; vc_num_rd = 4'b1000; tick();
    idle(); reset = 1; rd_en = 1; vc_num_rd = 4'b0001;
    tick(); idle();
    tests++;
    if (occ_y !== '0 || ne_y !== '0 || cr_y !== '0 || dv_y !== 1'b0
        || ovf_y !== 1'b0 || udf_y !== 1'b0) begin
      fails++; $display("FAIL mid_reset got occ=%h ne=%b c=%b v=%b o=%b u=%b exp 0",
                        occ_y, ne_y, cr_y, dv_y, ovf_y, udf_y);
    end
    rd_en = 1; vc_num_rd = 4'b0001;
    tick(); idle();
    tests++;
    if (udf_y !== 1'b1 || dv_y !== 1'b0 || cr_y !== '0) begin
      fails++; $display("FAIL mid_underflow got u=%b v=%b c=%b exp 1 0 0",
                        udf_y, dv_y, cr_y);
    end
  endtask

  task automatic test_random();
    logic [GW-1:0] got, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      wr_en = $urandom_range(0, 1);
      vc_num_wr = ($urandom_range(0, 15) == 0) ? V'($urandom) : V'(1 << $urandom_range(0, V-1));
      rd_en = ($urandom_range(0, 2) == 0);
      vc_num_rd = ($urandom_range(0, 15) == 0) ? V'($urandom) : V'(1 << $urandom_range(0, V-1));
      case ($urandom_range(0, 5))
        0, 1:    ssa_rd = V'(1 << $urandom_range(0, V-1));
        2:       ssa_rd = V'($urandom);
        default: ssa_rd = '0;
      endcase
      din = Fw'({$urandom, $urandom});
      tick();
      for (int m = 0; m < 2; m++) begin
        if (m == 0) got = {dout_y, dv_y, cr_y, occ_y, ne_y, full_y, af_y, ovf_y, udf_y};
        else        got = {dout_n, dv_n, cr_n, occ_n, ne_n, full_n, af_n, ovf_n, udf_n};
        exp = {m_dout[m], m_val[m], m_cred[m], e_occ(m), e_ne(m), e_full(m),
               e_af(m), m_ovf[m], m_udf[m]};
        tests++;
        if (got !== exp) begin
          fails++; $display("FAIL random c=%0d dut=%0d got %h exp %h", c, m, got, exp);
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_fill_overflow();
    test_drain();
    test_wrap();
    test_full_simul();
    test_ssa();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
